// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
// Optional START timeout is enabled by defining UART_SCHED_START_TMO_EN.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam int DEFAULT_GAP_CYCLES = 16;
    localparam int DEFAULT_START_TMO  = 4096;

    function automatic int grant_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester strictly after the
// last grant, wrapping with an explicit modulo so any NUM_REQ works.
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = grant_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [GRANT_W-1:0] i_last,
    output logic [NUM_REQ-1:0] o_pick_oh,
    output logic [GRANT_W-1:0] o_pick_idx,
    output logic               o_pick_valid
);

    logic [GRANT_W-1:0] w_cand;
    logic               w_found;

    // Scan NUM_REQ candidates starting one past the last grant; first hit wins.
    always_comb begin
        o_pick_oh  = '0;
        o_pick_idx = i_last;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = GRANT_W'((int'(i_last) + off) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found           = 1'b1;
                o_pick_idx        = w_cand;
                o_pick_oh[w_cand] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign o_pick_valid = w_found;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers with CTS gating and
// an inter-frame gap. Define UART_SCHED_START_TMO_EN to bound the wait in START.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int START_TMO  = DEFAULT_START_TMO
)(
    input  logic                         SysClk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req_Valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
    output logic [NUM_REQ-1:0]           Req_Ack,
    input  logic                         CTS,
    input  logic                         Tx_Busy,
    output logic [DATA_BITS-1:0]         Tx_Data,
    output logic                         Transmit_Start,
    output logic [grant_w(NUM_REQ)-1:0]  Grant_Id,
    output logic                         Sched_Busy,
    output logic                         Start_Tmo_Err
);

    localparam int GW    = grant_w(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_t         r_state;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_start;
    logic [DATA_BITS-1:0] r_data;
    logic [GW-1:0]        r_gid;
    logic                 r_busy;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_tmo_err;

    sched_state_t         w_state_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 w_start_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic [GW-1:0]        w_gid_nxt;
    logic [GAP_W-1:0]     w_gap_nxt;
    logic                 w_err_nxt;
    logic                 w_tmo_hit;

    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [GW-1:0]        w_pick_idx;
    logic                 w_pick_valid;
    logic [DATA_BITS-1:0] w_req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign w_req_bytes[g] = Req_Data[g*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GW)
    ) u_rr_pick (
        .i_req_valid  (Req_Valid),
        .i_last       (r_gid),
        .o_pick_oh    (w_pick_oh),
        .o_pick_idx   (w_pick_idx),
        .o_pick_valid (w_pick_valid)
    );

`ifdef UART_SCHED_START_TMO_EN
    localparam int TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    logic [TMO_W-1:0] r_tmo_cnt;

    // Cycles spent waiting in START for the UART to report busy.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == START) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1'b1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_state == START) && (r_tmo_cnt == TMO_W'(START_TMO - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and next-output decode; the gap counter idles at zero outside GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = '0;
        w_start_nxt = r_start;
        w_data_nxt  = r_data;
        w_gid_nxt   = r_gid;
        w_gap_nxt   = '0;
        w_err_nxt   = r_tmo_err;
        case (r_state)
            IDLE: begin
                if (CTS && w_pick_valid) begin
                    w_state_nxt = START;
                    w_ack_nxt   = w_pick_oh;
                    w_start_nxt = 1'b1;
                    w_data_nxt  = w_req_bytes[w_pick_idx];
                    w_gid_nxt   = w_pick_idx;
                end else begin
                    w_start_nxt = 1'b0;
                end
            end
            START: begin
                // A busy UART on entry counts as the launch of our frame.
                if (Tx_Busy) begin
                    w_state_nxt = BUSY;
                    w_start_nxt = 1'b0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                    w_start_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_start_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (!Tx_Busy) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_start_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_ack     <= '0;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_gid     <= GW'(NUM_REQ - 1);
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_start   <= w_start_nxt;
            r_data    <= w_data_nxt;
            r_gid     <= w_gid_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_gap_cnt <= w_gap_nxt;
            r_tmo_err <= w_err_nxt;
        end
    end

    assign Req_Ack        = r_ack;
    assign Transmit_Start = r_start;
    assign Tx_Data        = r_data;
    assign Grant_Id       = r_gid;
    assign Sched_Busy     = r_busy;
    assign Start_Tmo_Err  = r_tmo_err;

endmodule
